// File: rtl/n_bit_multicycle_subtractor.sv
// Iterative unsigned subtractor: DIFF = A - B - bin (mod 2^N), W bits per cycle, LSB chunk first.
// Valid/ready on both sides; result and borrow-out are registered.
module n_bit_multicycle_subtractor #(
  parameter int N = 47,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] DIFF,
  output logic         bout
);

  localparam int NCHUNK = (N + W - 1) / W;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST     = KW'(NCHUNK - 1);
  localparam logic [N:0]    ONE_EXT    = (N+1)'(1);
  localparam logic [N-1:0]  CHUNK_MASK = N'((ONE_EXT << W) - ONE_EXT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic          borrow_q, borrow_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          out_valid_q, out_valid_d;

  logic [31:0]   sh;
  logic [W-1:0]  a_chunk, b_chunk;
  logic [W:0]    sub;
  logic [N-1:0]  res_ext;
  logic          accept;

  assign in_ready  = reset_n && (state_q == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign DIFF      = diff_q;
  assign bout      = bout_q;

  // The last chunk's operands are zero-extended above the partial width, so
  // the sign bit sub[W] is exactly the borrow at that partial width.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    borrow_d    = borrow_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    out_valid_d = out_valid_q;

    sh      = 32'(k_q) * 32'(W);
    a_chunk = W'(a_q >> sh);
    b_chunk = W'(b_q >> sh);
    sub     = {1'b0, a_chunk} - {1'b0, b_chunk} - {{W{1'b0}}, borrow_q};
    res_ext = N'(sub[W-1:0]);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = A;
          b_d      = B;
          borrow_d = bin;
          k_d      = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        diff_d   = (diff_q & ~(CHUNK_MASK << sh)) | (res_ext << sh);
        borrow_d = sub[W];
        k_d      = k_q + 1'b1;
        if (k_q == K_LAST) begin
          bout_d      = sub[W];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: operand and running-borrow registers are datapath only, loaded on accept, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q      <= a_d;
    b_q      <= b_d;
    borrow_q <= borrow_d;
  end

endmodule

// File: tb/tb_n_bit_multicycle_subtractor.sv
// Bench for n_bit_multicycle_subtractor: three instances (W=16, W=N, W=1) share stimulus;
// directed vector table, backpressure and mid-operation reset sequences, then random regression.
module tb_n_bit_multicycle_subtractor;

  localparam int N = 47;

  logic         clk = 1'b0;
  logic         reset_n, in_valid, out_ready, bin;
  logic [N-1:0] a, b;
  logic [2:0]   in_ready, out_valid, bout;
  logic [N-1:0] diff [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    n_bit_multicycle_subtractor #(
      .N(N),
      .W(g == 0 ? 16 : (g == 1 ? N : 1))
    ) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready[g]),
      .A        (a),
      .B        (b),
      .bin      (bin),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .DIFF     (diff[g]),
      .bout     (bout[g])
    );
  end

  function automatic int nchunk(input int g);
    int w;
    w = (g == 0) ? 16 : ((g == 1) ? N : 1);
    return (N + w - 1) / w;
  endfunction

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vbin);
    int t = 0;
    while (in_ready != 3'b111 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("start_in_ready", N'(in_ready), N'(3'b111));
    a        = va;
    b        = vb;
    bin      = vbin;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int lat [3];
    int n = 0;
    for (int g = 0; g < 3; g++) lat[g] = 0;
    while (out_valid != 3'b111 && n < 100) begin
      @(negedge clk);
      n++;
      for (int g = 0; g < 3; g++)
        if (out_valid[g] && lat[g] == 0) lat[g] = n;
    end
    for (int g = 0; g < 3; g++)
      check($sformatf("latency_inst%0d", g), N'(lat[g]), N'(nchunk(g)));
  endtask

  task automatic finish_op(input logic [N-1:0] exp_d, input logic exp_b, input int stall);
    out_ready = 1'b0;
    repeat (stall) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("diff_inst%0d", g), diff[g], exp_d);
      check($sformatf("bout_inst%0d", g), N'(bout[g]), N'(exp_b));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_hs", N'(out_valid), N'(3'b000));
    check("in_ready_after_hs", N'(in_ready), N'(3'b111));
  endtask

  initial begin
    logic [N-1:0] ra, rb, hold_d;
    logic         rbin;
    logic [N:0]   t;

    vecs[0] = '{a: 47'd5,              b: 47'd3,              bin: 1'b0, d: 47'd2,              bo: 1'b0};
    vecs[1] = '{a: 47'd0,              b: 47'd1,              bin: 1'b0, d: 47'h7FFF_FFFF_FFFF, bo: 1'b1};
    vecs[2] = '{a: 47'h1_0000,         b: 47'd1,              bin: 1'b0, d: 47'h0_FFFF,         bo: 1'b0};
    vecs[3] = '{a: 47'h7FFF_FFFF_FFFF, b: 47'h7FFF_FFFF_FFFF, bin: 1'b1, d: 47'h7FFF_FFFF_FFFF, bo: 1'b1};
    vecs[4] = '{a: 47'd0,              b: 47'd0,              bin: 1'b1, d: 47'h7FFF_FFFF_FFFF, bo: 1'b1};
    vecs[5] = '{a: 47'h1234_5678_9ABC, b: 47'h0234_5678_9ABC, bin: 1'b0, d: 47'h1000_0000_0000, bo: 1'b0};
    vecs[6] = '{a: 47'h4000_0000_0000, b: 47'd1,              bin: 1'b0, d: 47'h3FFF_FFFF_FFFF, bo: 1'b0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready_low", N'(in_ready), N'(3'b000));
    check("rst_out_valid", N'(out_valid), N'(3'b000));
    check("rst_bout", N'(bout), N'(3'b000));
    check("rst_diff", diff[0], '0);
    reset_n = 1'b1;
    #1;
    check("post_rst_in_ready", N'(in_ready), N'(3'b111));

    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done();
      finish_op(vecs[i].d, vecs[i].bo, i % 3);
    end

    // Backpressure: hold result while new operands wait on in_valid.
    start_op(47'd5, 47'd3, 1'b0);
    wait_done();
    a         = 47'h1_0000;
    b         = 47'd1;
    bin       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_diff_hold", diff[0], 47'd2);
      check("bp_bout_hold", N'(bout[0]), '0);
      check("bp_out_valid", N'(out_valid[0]), N'(1'b1));
      check("bp_in_ready_low", N'(in_ready[0]), '0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_out_valid_drop", N'(out_valid), N'(3'b000));
    check("bp_in_ready_rise", N'(in_ready), N'(3'b111));
    @(negedge clk);
    in_valid = 1'b0;
    wait_done();
    finish_op(47'h0_FFFF, 1'b0, 0);

    // Reset while the W=16 instance is between chunk 0 and chunk 1.
    start_op(47'd0, 47'd1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready_low", N'(in_ready), N'(3'b000));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("midrst_out_valid", N'(out_valid), N'(3'b000));
    check("midrst_in_ready", N'(in_ready), N'(3'b111));
    check("midrst_bout", N'(bout), N'(3'b000));
    for (int g = 0; g < 3; g++) check($sformatf("midrst_diff_inst%0d", g), diff[g], '0);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra   = N'({$urandom, $urandom});
      rb   = N'({$urandom, $urandom});
      rbin = 1'($urandom_range(0, 1));
      if (i % 10 == 0) rb = ra;
      if (i % 10 == 1) ra = '0;
      t = {1'b0, ra} - {1'b0, rb} - (N+1)'(rbin);
      hold_d = t[N-1:0];
      start_op(ra, rb, rbin);
      wait_done();
      finish_op(hold_d, t[N], int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/n_bit_multicycle_subtractor.md
Name: n_bit_multicycle_subtractor

Overview:
- Iterative unsigned subtractor for the MAC datapath: DIFF = A - B - bin (mod 2^N), with borrow-out.
- Processes the N-bit operands in W-bit chunks, one chunk per cycle, LSB chunk first, so each cycle needs only one W-bit carry-lookahead subtract stage.
- Valid/ready handshakes on both sides let it sit between the operand staging registers and the accumulator writeback.

Parameters:
- N, 47: operand and result width in bits.
- W, 16: chunk width in bits. Legal range 1 <= W <= N.
- NCHUNK, derived as ceil(N/W), default 3: number of chunk cycles. This is a localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- A  input  N  minuend
- B  input  N  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- DIFF  output  N  difference, mod 2^N
- bout  output  1  borrow out; 1 iff A < B + bin as unsigned values

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: sampled on the clk edge while reset_n is 0. Sets state to IDLE, chunk index to 0, DIFF to 0, bout to 0, out_valid to 0.
- in_ready is 0 while reset_n is 0. Otherwise in_ready = (state == IDLE).
- IDLE:
  - Accept occurs when in_valid and in_ready are both 1 at a clk edge.
  - On accept: latch A, B and bin (bin becomes the running borrow). Clear chunk index. Go to BUSY.
  - Inputs are not sampled outside an accept.
- BUSY: each edge computes chunk k = chunk index.
  - The chunk covers bits [min(N, (k+1)W) - 1 : kW] and is computed as a_chunk - b_chunk - borrow.
  - Write the chunk result into the DIFF register slice. The running borrow takes this chunk's borrow-out. Increment k.
  - The last chunk is N - (NCHUNK-1)*W bits wide. Its borrow is taken at that partial width, not at W.
  - After the edge that processes chunk NCHUNK-1: bout = final borrow, out_valid = 1, state goes to DONE.
- Latency: out_valid rises exactly NCHUNK edges after the accept edge (3 with defaults). There is no combinational path from inputs to outputs.
- DONE:
  - DIFF, bout and out_valid hold stable until out_ready is 1 at an edge.
  - On that edge: out_valid goes to 0 and state goes to IDLE. in_ready is therefore 1 the following cycle. Throughput is one result per NCHUNK+2 cycles at most.
  - DIFF and bout retain their last values after the handshake, until the next result overwrites them chunk by chunk.
- in_valid while in BUSY or DONE is ignored. Operands are not queued. The upstream side must hold in_valid until it sees in_ready.
- out_ready while out_valid is 0 is ignored.
- Reset mid-operation (BUSY or DONE): reset takes priority. The next cycle shows IDLE with out_valid = 0, DIFF = 0 and bout = 0. The partial result is discarded.
- W = N gives a single-cycle compute (NCHUNK = 1).

Test Plan:
- A=5, B=3, bin=0, out_ready=1: DIFF=2, bout=0. out_valid high 3 cycles after the accept edge. in_ready is 1 again 2 cycles after the out_valid edge sequence completes.
- A=0, B=1, bin=0: DIFF=0x7FFF_FFFF_FFFF, bout=1. This checks that the borrow propagates through all three chunks and the 15-bit top chunk.
- A=0x1_0000, B=1, bin=0: DIFF=0x0_FFFF, bout=0. This checks the borrow crossing the chunk 0 to chunk 1 boundary.
- A=B=0x7FFF_FFFF_FFFF, bin=1: DIFF=0x7FFF_FFFF_FFFF, bout=1.
- Backpressure: out_ready held 0 for 5 cycles after out_valid, while in_valid=1 with new operands.
  - Required: DIFF and bout stable, in_ready=0, new operands not accepted.
  - After out_ready=1: out_valid=0 and in_ready=1 the next cycle, then the new operands are accepted.
- Reset and random regression:
  - Drop reset_n for one cycle during BUSY chunk 1. Next cycle: out_valid=0, in_ready=1, DIFF=0, bout=0.
  - Then run 1000 random {A, B, bin} with random out_ready stalls. Every result must match the golden {bout, DIFF} = {A < B+bin, (A - B - bin) mod 2^47}.
  - Repeat the regression with W=47 and W=1.
